cordic_rotate_serial: RTL
=========================

// Module: cordic_rotate_serial
// PURPOSE
//   Iterative CORDIC in rotation mode: the inverse of the vectoring/phase block.
//   Takes a signed angle (degrees * 2^16) and produces cos/sin scaled by 2^16.
//   Runs one micro-rotation per clock and accepts one angle at a time with a
//   valid/ready handshake. It feeds NCO/mixer logic next to the phase detector.
// PARAMETERS
//   ITER    16   number of micro-rotations (1..16); uses atan LUT entries 0..ITER-1
// PORTS
//   clk        in   1   single clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   angle_in is valid
//   in_ready   out  1   block is IDLE and can accept an angle
//   angle_in   in   32  signed angle, degrees*2^16 (90 deg = 5898240)
//   out_valid  out  1   one-cycle pulse: cos_out/sin_out updated
//   cos_out    out  32  signed cos(angle)*2^16
//   sin_out    out  32  signed sin(angle)*2^16
// BEHAVIOUR
//   - Reset (async): state=IDLE, iter=0, x/y/z=0, out_valid=0, cos_out=sin_out=0.
//     in_ready is 0 while rst is high.
//   - Data path is 32-bit signed. Shifts are arithmetic (>>>). Adds wrap (no saturation).
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     IDLE: in_ready=1 (combinational on state). On an edge with in_valid=1:
//       load x=K_INV (39797 = 0.607253*2^16), y=0, z=z0, iter=0; go to RUN.
//       in_valid=0 keeps the FSM in IDLE.
//     RUN: on each edge, d = ~z[31] (z>=0 gives d=+1).
//       d=+1: x-=y>>>iter; y+=x>>>iter; z-=ATAN[iter]
//       d=-1: x+=y>>>iter; y-=x>>>iter; z+=ATAN[iter]
//       All three updates use the pre-edge values. iter increments.
//       Move to DONE on the edge that executes iter==ITER-1.
//     DONE: cos_out<=x, sin_out<=y (negated when neg_flag=1), out_valid<=1, go to IDLE.
//   - Latency: out_valid is high in the cycle after edge E0+ITER+1, where E0 is the
//     accept edge (17 edges at default). Throughput is one angle per ITER+2 cycles.
//   - out_valid is a one-cycle pulse with no backpressure. cos_out/sin_out hold
//     their value until the next DONE.
//   - in_valid while in_ready=0 is ignored; nothing is queued. angle_in is sampled
//     only on the accept edge, so later changes have no effect.
//   - rst mid-operation aborts immediately. No out_valid pulse occurs for the
//     aborted angle, and the outputs return to 0.
//   - Accuracy at ITER=16: |cos_out-ideal|, |sin_out-ideal| <= 16 LSB.
// CONFIGURATION
//   CORDIC_QUAD_EXT_EN defined: quadrant folding. Legal range is [-180,+180] deg.
//     angle_in > 5898240 gives z0 = angle_in-11796480 and neg_flag=1.
//     angle_in < -5898240 gives z0 = angle_in+11796480 and neg_flag=1.
//     Otherwise z0 = angle_in and neg_flag=0.
//     The comparison is made on the accept edge and neg_flag is registered.
//   Not defined: z0 = angle_in and neg_flag is always 0.
//     Legal range is [-90,+90] deg. Outside that range the outputs are unspecified,
//     but the FSM still completes and pulses out_valid.
// STRUCTURE
//   Shared package cordic_pkg holds:
//     - ATAN_LUT[0:15] in deg*2^16 (2949120, 1740992, 919872, 466944, 234368,
//       117312, 58688, 29312, 14656, 7360, 3648, 1856, 896, 448, 256, 128);
//       the vectoring block uses the same table
//     - K_INV=39797, DEG90=5898240, DEG180=11796480
//     - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2
//   One sub-module, cordic_micro_rot: a combinational single iteration
//   (x, y, z, shift, atan, mode) -> (x', y', z'). The mode input lets the
//   vectoring block share the same sub-module.
// TESTING
//   1. angle_in=0 -> cos_out=65536+-16, sin_out=0+-16; out_valid 17 edges after accept.
//   2. angle_in=1966080 (30 deg) -> cos=56756+-16, sin=32768+-16.
//   3. angle_in=-2949120 (-45 deg) -> cos=46341+-16, sin=-46341+-16.
//      angle_in=5898240 (90 deg) -> cos=0+-16, sin=65536+-16.
//   4. CORDIC_QUAD_EXT_EN, angle_in=9830400 (150 deg) -> cos=-56756+-16, sin=32768+-16.
//      angle_in=-11796480 -> cos=-65536+-16, sin=0+-16.
//   5. in_valid held high with 4 different angles -> accepts exactly every 18 cycles;
//      4 out_valid pulses 18 cycles apart, each with the correct values;
//      angle_in changes while busy are ignored.
//   6. rst asserted during RUN at iter=5 -> out_valid stays 0 and outputs go to 0;
//      in_ready=1 on the first cycle after rst deasserts; the next angle computes
//      correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
//------------------------------------------------------------------------------
// Module   : cordic_pkg
// Purpose  : Shared constants and types for the CORDIC rotation/vectoring
//            blocks: the arctangent table (deg*2^16), CORDIC gain
//            compensation, angle constants and FSM state encoding.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cordic_pkg;

  // atan(2^-i) in degrees * 2^16; the vectoring block reads the same table
  localparam logic signed [31:0] ATAN_LUT [0:15] = '{
    32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
    32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
    32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
    32'sd896,     32'sd448,     32'sd256,    32'sd128
  };

  // 1/K = 0.607253 * 2^16: pre-scales x so the result lands at unit gain
  localparam logic signed [31:0] K_INV  = 32'sd39797;
  localparam logic signed [31:0] DEG90  = 32'sd5898240;
  localparam logic signed [31:0] DEG180 = 32'sd11796480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Table lookup by iteration index
  function automatic logic signed [31:0] atan_at(input logic [3:0] idx);
    return ATAN_LUT[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_micro_rot.sv
//------------------------------------------------------------------------------
// Module   : cordic_micro_rot
// Purpose  : One combinational CORDIC micro-rotation. mode=0 is rotation
//            (direction from the sign of z), mode=1 is vectoring (direction
//            chosen to drive y toward zero).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cordic_micro_rot (
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  input  logic signed [31:0] z_in,
  input  logic        [3:0]  shift,
  input  logic signed [31:0] atan,
  input  logic               mode,
  output logic signed [31:0] x_out,
  output logic signed [31:0] y_out,
  output logic signed [31:0] z_out
);

  logic signed [31:0] w_xs;
  logic signed [31:0] w_ys;
  logic               w_d_pos;

  // Select rotation direction and apply the shifted cross terms (wrapping adds)
  always_comb begin
    w_xs    = x_in >>> shift;
    w_ys    = y_in >>> shift;
    w_d_pos = mode ? y_in[31] : ~z_in[31];
    if (w_d_pos) begin
      x_out = x_in - w_ys;
      y_out = y_in + w_xs;
      z_out = z_in - atan;
    end else begin
      x_out = x_in + w_ys;
      y_out = y_in - w_xs;
      z_out = z_in + atan;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_rotate_serial.sv
//------------------------------------------------------------------------------
// Module   : cordic_rotate_serial
// Purpose  : Iterative rotation-mode CORDIC. Accepts one angle (deg*2^16)
//            through a valid/ready handshake, runs one micro-rotation per
//            clock and pulses out_valid with cos/sin scaled by 2^16.
//            Optional macro CORDIC_QUAD_EXT_EN enables quadrant folding so
//            the legal input range widens from +-90 to +-180 degrees.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cordic_rotate_serial
  import cordic_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] angle_in,
  output logic        out_valid,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out
);

  if ((ITER < 1) || (ITER > 16)) begin : g_iter_range_err
    $error("cordic_rotate_serial: ITER must be in 1..16");
  end

  localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

  state_t             r_state;
  logic        [3:0]  r_iter;
  logic signed [31:0] r_x;
  logic signed [31:0] r_y;
  logic signed [31:0] r_z;
  logic               r_neg;

  logic signed [31:0] w_z0;
  logic               w_neg;
  logic signed [31:0] w_x_nxt;
  logic signed [31:0] w_y_nxt;
  logic signed [31:0] w_z_nxt;

  // Ready only while idle and out of reset
  assign in_ready = (r_state == IDLE) && !rst;

  // Initial residual angle, folded into +-90 deg when the extension is built
  always_comb begin
`ifdef CORDIC_QUAD_EXT_EN
    if ($signed(angle_in) > DEG90) begin
      w_z0  = $signed(angle_in) - DEG180;
      w_neg = 1'b1;
    end else if ($signed(angle_in) < -DEG90) begin
      w_z0  = $signed(angle_in) + DEG180;
      w_neg = 1'b1;
    end else begin
      w_z0  = $signed(angle_in);
      w_neg = 1'b0;
    end
`else
    w_z0  = $signed(angle_in);
    w_neg = 1'b0;
`endif
  end

  cordic_micro_rot u_micro_rot (
    .x_in  (r_x),
    .y_in  (r_y),
    .z_in  (r_z),
    .shift (r_iter),
    .atan  (atan_at(r_iter)),
    .mode  (1'b0),
    .x_out (w_x_nxt),
    .y_out (w_y_nxt),
    .z_out (w_z_nxt)
  );

  // Control FSM and datapath registers; out_valid defaults low each edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_iter    <= 4'd0;
      r_x       <= 32'sd0;
      r_y       <= 32'sd0;
      r_z       <= 32'sd0;
      r_neg     <= 1'b0;
      out_valid <= 1'b0;
      cos_out   <= 32'd0;
      sin_out   <= 32'd0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x     <= K_INV;
            r_y     <= 32'sd0;
            r_z     <= w_z0;
            r_neg   <= w_neg;
            r_iter  <= 4'd0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + 4'd1;
          if (r_iter == LAST_ITER) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          cos_out   <= r_neg ? 32'(-r_x) : 32'(r_x);
          sin_out   <= r_neg ? 32'(-r_y) : 32'(r_y);
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
